// File: rtl/paddle_move_ctrl_if.sv
// Bundle of step-pulse inputs and paddle-position outputs between the
// direction detectors / game control and the paddle movement block.
interface paddle_move_ctrl_if #(
  parameter int POS_W = 4
);
  logic             p1_left;
  logic             p1_right;
  logic             p2_left;
  logic             p2_right;
  logic             game_run;
  logic             serve;
  logic [POS_W-1:0] p1_pos;
  logic [POS_W-1:0] p2_pos;
  logic             p1_wall;
  logic             p2_wall;
  logic [1:0]       state;

  modport master (
    output p1_left, p1_right, p2_left, p2_right, game_run, serve,
    input  p1_pos, p2_pos, p1_wall, p2_wall, state
  );

  modport slave (
    input  p1_left, p1_right, p2_left, p2_right, game_run, serve,
    output p1_pos, p2_pos, p1_wall, p2_wall, state
  );
endinterface

// File: rtl/paddle_move_ctrl.sv
// Turns per-player left/right step pulses into rate-limited, saturating
// paddle positions, gated by a small IDLE/CENTER/RUN game-state machine.
module paddle_move_ctrl #(
  parameter int POS_W      = 4,
  parameter int POS_MAX    = 12,
  parameter int POS_CENTER = 6,
  parameter int COOLDOWN   = 3
) (
  input logic              clk,
  input logic              rst_n,
  paddle_move_ctrl_if.slave bus
);

  localparam int CD_W = $clog2(COOLDOWN + 1);
  localparam logic signed [POS_W+1:0] MAX_S = (POS_W+2)'(POS_MAX);
  localparam logic [POS_W-1:0] CENTER_POS = POS_W'(POS_CENTER);
  localparam logic [CD_W-1:0]  CD_LOAD    = CD_W'(COOLDOWN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CENTER = 2'd1,
    RUN    = 2'd2
  } state_t;

  // +1 right, -1 left, 0 when neither or both are pressed
  function automatic logic signed [1:0] decode_req(input logic l, input logic r);
    if (r && !l)      return 2'sd1;
    else if (l && !r) return -2'sd1;
    else              return 2'sd0;
  endfunction

  // Returns {wall, next_pos}; a step past either bound leaves pos unchanged
  function automatic logic [POS_W:0] sat_step(input logic [POS_W-1:0] pos,
                                              input logic signed [1:0] dir);
    logic signed [POS_W+1:0] t;
    t = $signed({2'b00, pos}) + (POS_W+2)'(dir);
    if (t < 0 || t > MAX_S) return {1'b1, pos};
    else                    return {1'b0, t[POS_W-1:0]};
  endfunction

  state_t                  state_p1;
  logic [POS_W-1:0]        pos_p1  [2];
  logic                    wall_p1 [2];
  logic [CD_W-1:0]         cd_p1   [2];
  logic signed [1:0]       pend_p1 [2];

  logic [1:0]              left, right;
  logic signed [1:0]       req     [2];
  logic signed [1:0]       use_dir [2];
  logic [POS_W:0]          step    [2];
  logic                    move_en;

  assign left  = {bus.p2_left,  bus.p1_left};
  assign right = {bus.p2_right, bus.p1_right};

  // Request decode: a fresh request outranks the pending slot
  always_comb begin
    move_en = (state_p1 == RUN) && bus.game_run && !bus.serve;
    for (int i = 0; i < 2; i++) begin
      req[i]     = decode_req(left[i], right[i]);
      use_dir[i] = (req[i] != 2'sd0) ? req[i] : pend_p1[i];
      step[i]    = sat_step(pos_p1[i], use_dir[i]);
    end
  end

  // State, positions, cooldowns and pending slots update together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      for (int i = 0; i < 2; i++) begin
        pos_p1[i]  <= CENTER_POS;
        wall_p1[i] <= 1'b0;
        cd_p1[i]   <= '0;
        pend_p1[i] <= 2'sd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        wall_p1[i] <= 1'b0;
        if (cd_p1[i] != '0) cd_p1[i] <= cd_p1[i] - CD_W'(1);
      end
      case (state_p1)
        IDLE: begin
          for (int i = 0; i < 2; i++) pend_p1[i] <= 2'sd0;
          if (bus.serve) state_p1 <= CENTER;
        end
        CENTER: begin
          for (int i = 0; i < 2; i++) begin
            pos_p1[i]  <= CENTER_POS;
            cd_p1[i]   <= '0;
            pend_p1[i] <= 2'sd0;
          end
          state_p1 <= bus.game_run ? RUN : IDLE;
        end
        RUN: begin
          if (!move_en) begin
            for (int i = 0; i < 2; i++) pend_p1[i] <= 2'sd0;
            state_p1 <= bus.serve ? CENTER : IDLE;
          end else begin
            for (int i = 0; i < 2; i++) begin
              if (cd_p1[i] == '0) begin
                if (use_dir[i] != 2'sd0) begin
                  pos_p1[i]  <= step[i][POS_W-1:0];
                  wall_p1[i] <= step[i][POS_W];
                  cd_p1[i]   <= CD_LOAD;
                  pend_p1[i] <= 2'sd0;
                end
              end else if (req[i] != 2'sd0) begin
                pend_p1[i] <= req[i];
              end
            end
          end
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  assign bus.p1_pos  = pos_p1[0];
  assign bus.p2_pos  = pos_p1[1];
  assign bus.p1_wall = wall_p1[0];
  assign bus.p2_wall = wall_p1[1];
  assign bus.state   = state_p1;

endmodule

// File: doc/paddle_move_ctrl.md
Name: paddle_move_ctrl

Overview:
- Consumes the left/right step pulses produced by two per-player direction detectors (one per player's 3-position input).
- Converts those pulses into rate-limited, saturating paddle positions for the pong display and scoring logic.
- A small state machine gates movement on game state and recentres both paddles on serve.
- Sits between the direction detectors and the video/collision datapath.

Parameters:
- POS_W, 4, width of each paddle position bus.
- POS_MAX, 12, highest legal paddle position; legal range is 0..POS_MAX, and POS_MAX < 2^POS_W.
- POS_CENTER, 6, position loaded on reset and on recentre.
- COOLDOWN, 3, clock cycles after an applied move during which no further move is applied for that player; must be ≥ 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- p1_left  in  1  player-1 left step pulse, 1-cycle
- p1_right  in  1  player-1 right step pulse, 1-cycle
- p2_left  in  1  player-2 left step pulse, 1-cycle
- p2_right  in  1  player-2 right step pulse, 1-cycle
- game_run  in  1  level; 1 = rally in progress
- serve  in  1  1-cycle request to recentre paddles and start a rally
- p1_pos  out  POS_W  player-1 paddle position
- p2_pos  out  POS_W  player-2 paddle position
- p1_wall  out  1  1-cycle pulse: player-1 move rejected at a bound
- p2_wall  out  1  1-cycle pulse: player-2 move rejected at a bound
- state  out  2  FSM state: 0 = IDLE, 1 = CENTER, 2 = RUN

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - p1_pos = p2_pos = POS_CENTER.
  - Wall pulses = 0, state = IDLE.
  - Cooldown counters = 0, pending requests cleared.
- FSM:
  - IDLE → CENTER when serve = 1.
  - CENTER lasts exactly one cycle: both positions load POS_CENTER and all pending requests and cooldowns clear. Then go to RUN if game_run = 1, else IDLE.
  - RUN → IDLE when game_run = 0. Positions hold.
  - RUN → CENTER when serve = 1. Serve has priority over game_run deassertion.
  - In IDLE, step pulses are ignored and are not latched.
- Per-player request decode (RUN only, each player independent):
  - left & right in the same cycle → no request.
  - left only → request −1.
  - right only → request +1.
- Move application, per player:
  - If cooldown = 0 and a request is present (new this cycle, or pending), apply it on this edge.
    - Position updates the cycle after the pulse, so latency is 1 clock.
    - Cooldown loads COOLDOWN.
  - An applied move that would take the position below 0 or above POS_MAX leaves the position unchanged and asserts the wall pulse for exactly 1 cycle.
    - Cooldown still loads COOLDOWN.
  - If cooldown > 0, a new request is stored in a depth-1 pending slot.
    - A later request overwrites the slot (newest wins).
    - An opposite-direction request overwrites it the same way.
  - Cooldown decrements by 1 per cycle while > 0.
  - A new request arriving in the cycle cooldown reaches 0 takes priority over the pending slot; the slot is then cleared.
- Positions change only by ±1 per applied move and never leave 0..POS_MAX.
- Leaving RUN (to IDLE or CENTER) clears pending slots. Cooldown counters keep running down in IDLE.
- Reset asserted mid-rally returns everything to the reset values immediately, without waiting for a clock edge.

Test Plan:
- Recentre from IDLE:
  - Stimulus: reset, then serve with game_run = 1.
  - Response: state goes IDLE → CENTER → RUN on successive edges; p1_pos = p2_pos = 6.
- Single step latency:
  - Stimulus: in RUN, p1_right pulse at cycle t.
  - Response: p1_pos = 7 at t+1; p2_pos stays 6.
- Rate limit and pending slot:
  - Stimulus: p1_right at t, then p1_left at t+1 and p1_right at t+2.
  - Response: p1_pos = 7 at t+1. Pending slot holds +1 (newest wins). p1_pos = 8 once cooldown has expired, with cooldown reloaded at that move. No other changes.
- Upper bound:
  - Stimulus: drive p2 to 12, then one more p2_right after cooldown.
  - Response: p2_pos stays 12; p2_wall high for exactly 1 cycle.
- Simultaneous and gated inputs:
  - Stimulus: p1_left and p1_right together → no change, no wall pulse. Then game_run = 0 and p1_right.
  - Response: state = IDLE; p1_pos unchanged.
- Asynchronous reset mid-rally:
  - Stimulus: positions at 2 and 11 with a pending request; pull rst_n low between clock edges.
  - Response: both positions read 6 and state = IDLE immediately. No move is applied after rst_n rises until the next serve.
